regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file. It is the successor to the

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clear_fsm.sv | 60 ++++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file constants and clear-engine state encoding
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential zeroing sweep; holds the array out of RUN until done
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e     state, state_next;
  logic [AW-1:0] idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = clr_idx;
    case (state)
      CLEAR: begin
        // The index parks at zero on exit so it never wraps past the last register
        if (clr_idx == LAST_IDX) begin
          state_next = RUN;
          idx_next   = '0;
        end else begin
          idx_next = clr_idx + AW'(1);
        end
      end
      RUN: begin
        if (clear_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        idx_next   = '0;
      end
    endcase
  end

  assign clr_en    = (state == CLEAR) && !rst;
  assign init_done = (state == RUN);

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - 2-read/2-write integer register file with x0, bypass and clear engine
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  bit BYPASS = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_req,
  output logic            init_done,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  input  logic [AW-1:0]   rd0,
  input  logic            write_enable0,
  input  logic [XLEN-1:0] write_data0,
  input  logic [AW-1:0]   rd1,
  input  logic            write_enable1,
  input  logic [XLEN-1:0] write_data1,
  output logic            wr_conflict
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [XLEN-1:0] mem [NREGS];
  logic            clr_en;
  logic [AW-1:0]   clr_idx;
  logic            wr_ok;
  logic            same_rd;
  logic            do_wr0;
  logic            do_wr1;
  logic [AW-1:0]   rs_sel [2];
  logic [XLEN-1:0] rdata  [2];

  regfile_clear_fsm #(.NREGS(NREGS)) u_clear_fsm (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx),
    .init_done (init_done)
  );

  // A clear request takes the array away this cycle, so its writes are dropped
  assign wr_ok   = init_done && !clear_req && !rst;
  assign same_rd = write_enable0 && write_enable1 && (rd0 == rd1) && (rd0 != ZERO_IDX);
  assign do_wr1  = wr_ok && write_enable1 && (rd1 != ZERO_IDX);
  assign do_wr0  = wr_ok && write_enable0 && (rd0 != ZERO_IDX) && !same_rd;

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else begin
      if (do_wr0) mem[rd0] <= write_data0;
      if (do_wr1) mem[rd1] <= write_data1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wr_conflict <= 1'b0;
    else     wr_conflict <= wr_ok && same_rd;
  end

  assign rs_sel[0] = rs1;
  assign rs_sel[1] = rs2;

  // Bypass order mirrors commit order: port 1 beats port 0
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if (init_done && rs_sel[p] != ZERO_IDX) begin
        if (BYPASS && write_enable1 && rd1 == rs_sel[p])
          rdata[p] = write_data1;
        else if (BYPASS && write_enable0 && rd0 == rs_sel[p])
          rdata[p] = write_data0;
        else
          rdata[p] = mem[rs_sel[p]];
      end
    end
  end

  assign read_data1 = rdata[0];
  assign read_data2 = rdata[1];

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - table, directed and random checks of regfile_mp against a reference model
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst, clear_req;
  logic [4:0]  rs1, rs2, rd0, rd1;
  logic        we0, we1;
  logic [31:0] wd0, wd1;
  logic        idb, wcb, idn, wcn;
  logic [31:0] rdb1, rdb2, rdn1, rdn2;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [32];
  int          m_cnt;
  logic        m_conf;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clear_req(clear_req), .init_done(idb),
    .rs1(rs1), .rs2(rs2), .read_data1(rdb1), .read_data2(rdb2),
    .rd0(rd0), .write_enable0(we0), .write_data0(wd0),
    .rd1(rd1), .write_enable1(we1), .write_data1(wd1),
    .wr_conflict(wcb)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .clear_req(clear_req), .init_done(idn),
    .rs1(rs1), .rs2(rs2), .read_data1(rdn1), .read_data2(rdn2),
    .rd0(rd0), .write_enable0(we0), .write_data0(wd0),
    .rd1(rd1), .write_enable1(we1), .write_data1(wd1),
    .wr_conflict(wcn)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  rd0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  rd1;
    logic [31:0] wd1;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        econf;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] rs, input bit byp);
    if (m_cnt != 0 || rs == 5'd0) return 32'd0;
    if (byp && we1 && rd1 == rs) return wd1;
    if (byp && we0 && rd0 == rs) return wd0;
    return m_mem[rs];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_cnt  = 32;
      m_conf = 1'b0;
    end else if (m_cnt != 0) begin
      m_mem[32 - m_cnt] = 32'd0;
      m_cnt--;
      m_conf = 1'b0;
    end else if (clear_req) begin
      m_cnt  = 32;
      m_conf = 1'b0;
    end else begin
      m_conf = we0 && we1 && rd0 == rd1 && rd0 != 5'd0;
      if (we0 && rd0 != 5'd0) m_mem[rd0] = wd0;
      if (we1 && rd1 != 5'd0) m_mem[rd1] = wd1;
    end
  endtask

  task automatic step();
    #1;
    chk("byp_rd1", rdb1, exp_read(rs1, 1'b1));
    chk("byp_rd2", rdb2, exp_read(rs2, 1'b1));
    chk("nob_rd1", rdn1, exp_read(rs1, 1'b0));
    chk("nob_rd2", rdn2, exp_read(rs2, 1'b0));
    @(posedge clk);
    model_edge();
    #1;
    chk("init_done_b", {31'd0, idb}, {31'd0, m_cnt == 0});
    chk("init_done_n", {31'd0, idn}, {31'd0, m_cnt == 0});
    chk("conflict_b", {31'd0, wcb}, {31'd0, m_conf});
    chk("conflict_n", {31'd0, wcn}, {31'd0, m_conf});
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    we0 = 1'b0; we1 = 1'b0;
    rd0 = 5'd0; rd1 = 5'd0;
    wd0 = 32'd0; wd1 = 32'd0;
  endtask

  task automatic all_zero(input string tag);
    for (int r = 0; r < 32; r++) begin
      rs1 = 5'(r);
      rs2 = 5'(31 - r);
      #1;
      chk({tag, "_b1"}, rdb1, 32'd0);
      chk({tag, "_n1"}, rdn1, 32'd0);
      chk({tag, "_b2"}, rdb2, 32'd0);
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd4,  32'd40,    1'b0, 5'd0, 32'd0,      5'd4, 5'd0,  32'd40,     32'd0,      1'b0};
    tbl[1] = '{1'b1, 5'd10, 32'd100,   1'b0, 5'd0, 32'd0,      5'd4, 5'd10, 32'd40,     32'd100,    1'b0};
    tbl[2] = '{1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 32'd0,      5'd4, 5'd10, 32'd40,     32'd100,    1'b0};
    tbl[3] = '{1'b1, 5'd0,  32'd100,   1'b1, 5'd0, 32'd100,    5'd0, 5'd0,  32'd0,      32'd0,      1'b0};
    tbl[4] = '{1'b1, 5'd7,  32'h11,    1'b1, 5'd7, 32'h22,     5'd7, 5'd7,  32'h22,     32'h22,     1'b1};
    tbl[5] = '{1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 32'd0,      5'd7, 5'd4,  32'h22,     32'd40,     1'b0};
    tbl[6] = '{1'b0, 5'd0,  32'd0,     1'b1, 5'd6, 32'hABCD,   5'd6, 5'd6,  32'hABCD,   32'hABCD,   1'b0};
    tbl[7] = '{1'b1, 5'd5,  32'd1,     1'b1, 5'd6, 32'd2,      5'd5, 5'd6,  32'd1,      32'd2,      1'b0};
    tbl[8] = '{1'b0, 5'd0,  32'd0,     1'b0, 5'd0, 32'd0,      5'd5, 5'd6,  32'd1,      32'd2,      1'b0};

    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0;

    // Reset sequence; writes attempted during the sweep must vanish
    rst = 1'b1;
    @(posedge clk);
    m_cnt = 32; m_conf = 1'b0;
    #1;
    chk("rst_init_done", {31'd0, idb}, 32'd0);
    chk("rst_conflict", {31'd0, wcb}, 32'd0);
    rst = 1'b0;
    we0 = 1'b1; rd0 = 5'd9; wd0 = 32'hDEAD_BEEF;
    for (int e = 0; e < 32; e++) begin
      chk("sweep_busy", {31'd0, idb}, 32'd0);
      step();
    end
    chk("sweep_done", {31'd0, idb}, 32'd1);
    idle_inputs();
    all_zero("after_reset");

    // Basic writes, x0 protection, collision, bypass
    for (int i = 0; i < 9; i++) begin
      we0 = tbl[i].we0; rd0 = tbl[i].rd0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; rd1 = tbl[i].rd1; wd1 = tbl[i].wd1;
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      #1;
      chk($sformatf("tbl%0d_rd1", i), rdb1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), rdb2, tbl[i].e2);
      step();
      chk($sformatf("tbl%0d_conf", i), {31'd0, wcb}, {31'd0, tbl[i].econf});
    end

    // Same-cycle visibility differs between the two bypass settings
    idle_inputs();
    we1 = 1'b1; rd1 = 5'd5; wd1 = 32'hABCD; rs2 = 5'd5;
    #1;
    chk("bypass_new", rdb2, 32'hABCD);
    chk("nobypass_old", rdn2, 32'd1);
    step();
    idle_inputs();
    #1;
    chk("nobypass_after", rdn2, 32'hABCD);

    // Clear mid-run with a colliding write, then reset partway into the sweep
    we0 = 1'b1; rd0 = 5'd3; wd0 = 32'h55;
    step();
    clear_req = 1'b1;
    we0 = 1'b1; rd0 = 5'd3; wd0 = 32'h33;
    we1 = 1'b1; rd1 = 5'd3; wd1 = 32'h44;
    step();
    chk("clr_init_done", {31'd0, idb}, 32'd0);
    chk("clr_no_conflict", {31'd0, wcb}, 32'd0);
    idle_inputs();
    for (int e = 0; e < 12; e++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (!idb && n < 40) begin
      step();
      n++;
    end
    chk("restart_len", 32'(n), 32'd32);
    all_zero("after_clear");

    // Random traffic against the model
    for (int it = 0; it < 400; it++) begin
      rst       = ($urandom_range(0, 127) == 0);
      clear_req = ($urandom_range(0, 63) == 0);
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      rd0 = 5'($urandom_range(0, 7));
      rd1 = 5'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
